// File: rtl/pot_pkg.sv
// Shared definitions for the digipot SPI frame path: FSM states and command constants.
package pot_pkg;

  localparam int unsigned FRAME_W = 16;

  localparam logic [15:0] POT_CMD_RESET     = 16'h1000;
  localparam logic [15:0] POT_CMD_CFG       = 16'h1802;
  localparam logic [5:0]  POT_CMD_WR_PREFIX = 6'b000001;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MSB,
    ST_LSB,
    ST_CSWAIT,
    ST_GAP
  } pot_state_e;

  // Wiper write frame: command prefix followed by the 10-bit wiper code.
  function automatic logic [15:0] pot_wr_frame(input logic [9:0] code);
    return {POT_CMD_WR_PREFIX, code};
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request after ptr_i, wrapping.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [2:0]         ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [2:0]         idx_o,
  output logic               valid_o
);

  localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  int unsigned   cand;
  logic [IW-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand     = (32'(ptr_i) + off) % NUM_REQ;
      cand_idx = IW'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        gnt_o[cand_idx] = 1'b1;
        idx_o           = 3'(cand);
        valid_o         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pot_spi_arbiter.sv
// Shares one byte-oriented SPI master among NUM_REQ digipot requesters; two bytes per CS frame,
// round-robin grant, inter-frame gap and a watchdog that aborts stuck handshakes.
module pot_spi_arbiter
  import pot_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 3,
  parameter int unsigned FRAME_GAP = 4,
  parameter int unsigned TIMEOUT   = 1023
) (
  input  logic                       clk,
  input  logic                       i_Rst_L,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [FRAME_W*NUM_REQ-1:0] req_frame,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [7:0]                 spi_tx_byte,
  output logic                       spi_tx_dv,
  input  logic                       spi_tx_ready,
  input  logic                       spi_cs_n,
  output logic                       busy,
  output logic [2:0]                 grant_id,
  output logic                       timeout_err
);

  localparam int unsigned WDW = $clog2(TIMEOUT + 1);

  pot_state_e           state_q, state_d;
  logic [FRAME_W-1:0]   frame_q, frame_d;
  logic [2:0]           grant_q, grant_d;
  logic [2:0]           rr_q, rr_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 busy_q, busy_d;
  logic                 dv_q, dv_d;
  logic [7:0]           byte_q, byte_d;
  logic                 cs_seen_q, cs_seen_d;
  logic [7:0]           gap_q, gap_d;
  logic [WDW-1:0]       wd_q, wd_d;
  logic                 terr_q, terr_d;

  logic [NUM_REQ-1:0]   arb_gnt;
  logic [2:0]           arb_idx;
  logic                 arb_valid;
  logic [FRAME_W-1:0]   arb_frame;
  logic [NUM_REQ-1:0]   grant_vec;
  logic                 wd_hit;
  logic                 gap_last;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i   (req_valid),
    .ptr_i   (rr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  always_comb begin
    arb_frame = '0;
    grant_vec = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) arb_frame = req_frame[i*FRAME_W +: FRAME_W];
      grant_vec[i] = (grant_q == 3'(i));
    end
  end

  assign wd_hit   = (wd_q == WDW'(TIMEOUT - 1));
  assign gap_last = (state_q == ST_GAP) && (gap_q == 8'(FRAME_GAP - 1));

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    grant_d   = grant_q;
    rr_d      = rr_q;
    ack_d     = '0;
    busy_d    = busy_q;
    dv_d      = 1'b0;
    byte_d    = byte_q;
    cs_seen_d = cs_seen_q | ~spi_cs_n;
    gap_d     = gap_q;
    wd_d      = wd_q + 1'b1;
    terr_d    = terr_q;

    unique case (state_q)
      ST_IDLE: begin
        wd_d      = '0;
        cs_seen_d = 1'b0;
        if (arb_valid) begin
          frame_d = arb_frame;
          ack_d   = arb_gnt;
          grant_d = arb_idx;
          rr_d    = arb_idx;
          busy_d  = 1'b1;
          state_d = ST_MSB;
        end
      end
      ST_MSB: begin
        if (wd_hit) begin
          terr_d  = 1'b1;
          wd_d    = '0;
          state_d = ST_GAP;
        end else if (spi_tx_ready) begin
          byte_d  = frame_q[15:8];
          dv_d    = 1'b1;
          wd_d    = '0;
          state_d = ST_LSB;
        end
      end
      ST_LSB: begin
        // dv_q is high only on the first LSB cycle; ready still reflects the previous byte then.
        if (wd_hit) begin
          terr_d  = 1'b1;
          wd_d    = '0;
          state_d = ST_GAP;
        end else if (!dv_q && spi_tx_ready) begin
          byte_d  = frame_q[7:0];
          dv_d    = 1'b1;
          wd_d    = '0;
          state_d = ST_CSWAIT;
        end
      end
      ST_CSWAIT: begin
        if (wd_hit) begin
          terr_d  = 1'b1;
          wd_d    = '0;
          state_d = ST_GAP;
        end else if (cs_seen_q && spi_cs_n) begin
          wd_d    = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        wd_d = '0;
        if (gap_last) begin
          gap_d   = '0;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q   <= ST_IDLE;
      frame_q   <= '0;
      grant_q   <= '0;
      rr_q      <= 3'(NUM_REQ - 1);
      ack_q     <= '0;
      busy_q    <= 1'b0;
      dv_q      <= 1'b0;
      byte_q    <= '0;
      cs_seen_q <= 1'b0;
      gap_q     <= '0;
      wd_q      <= '0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      frame_q   <= frame_d;
      grant_q   <= grant_d;
      rr_q      <= rr_d;
      ack_q     <= ack_d;
      busy_q    <= busy_d;
      dv_q      <= dv_d;
      byte_q    <= byte_d;
      cs_seen_q <= cs_seen_d;
      gap_q     <= gap_d;
      wd_q      <= wd_d;
      terr_q    <= terr_d;
    end
  end

  assign req_ack     = ack_q;
  assign req_done    = gap_last ? grant_vec : '0;
  assign spi_tx_byte = byte_q;
  assign spi_tx_dv   = dv_q;
  assign busy        = busy_q;
  assign grant_id    = grant_q;
  assign timeout_err = terr_q;

endmodule

// File: tb/tb_pot_spi_arbiter.sv
// Directed bench for pot_spi_arbiter with a small behavioural SPI master model.
module tb_pot_spi_arbiter;
  import pot_pkg::*;

  localparam int unsigned NREQ = 3;
  localparam int unsigned GAP  = 4;
  localparam int unsigned TMO  = 100;

  logic                clk = 1'b0;
  logic                i_Rst_L = 1'b0;
  logic [NREQ-1:0]     req_valid;
  logic [16*NREQ-1:0]  req_frame;
  logic [NREQ-1:0]     req_ack, req_done;
  logic [7:0]          spi_tx_byte;
  logic                spi_tx_dv;
  logic                spi_tx_ready;
  logic                spi_cs_n;
  logic                busy;
  logic [2:0]          grant_id;
  logic                timeout_err;
  logic                stall_ready = 1'b0;

  int n_cmp = 0;
  int n_err = 0;

  // SPI master model state and logs
  int          cyc, dv_cnt, consec, coincide, cs_rise_cyc, done_cyc, sh, nb;
  logic        prev_dv;
  int          ack_cnt [NREQ];
  int          ack_order [$];
  logic [7:0]  rx_q [$];

  always #5 clk = ~clk;

  pot_spi_arbiter #(
    .NUM_REQ   (NREQ),
    .FRAME_GAP (GAP),
    .TIMEOUT   (TMO)
  ) dut (
    .clk          (clk),
    .i_Rst_L      (i_Rst_L),
    .req_valid    (req_valid),
    .req_frame    (req_frame),
    .req_ack      (req_ack),
    .req_done     (req_done),
    .spi_tx_byte  (spi_tx_byte),
    .spi_tx_dv    (spi_tx_dv),
    .spi_tx_ready (spi_tx_ready),
    .spi_cs_n     (spi_cs_n),
    .busy         (busy),
    .grant_id     (grant_id),
    .timeout_err  (timeout_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({req_ack, req_done, spi_tx_dv, spi_tx_byte, busy, grant_id, timeout_err});
  endfunction

  function automatic logic [15:0] last_frame();
    if (rx_q.size() < 2) return 16'hxxxx;
    return {rx_q[rx_q.size()-2], rx_q[rx_q.size()-1]};
  endfunction

  // Requesters hold valid until they see their ack.
  task automatic tick();
    @(negedge clk);
    req_valid = req_valid & ~req_ack;
  endtask

  task automatic wait_ack(input int idx, input int budget);
    int   n = 0;
    logic seen = 1'b0;
    while (!seen && n < budget) begin
      tick();
      seen = req_ack[idx];
      n++;
    end
    check_eq($sformatf("ack%0d_seen", idx), 32'(seen), 32'd1);
  endtask

  task automatic wait_done(input int idx, input int budget);
    int   n = 0;
    logic seen = 1'b0;
    while (!seen && n < budget) begin
      tick();
      seen = req_done[idx];
      n++;
    end
    check_eq($sformatf("done%0d_seen", idx), 32'(seen), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    i_Rst_L = 1'b0;
    tick();
    tick();
    i_Rst_L = 1'b1;
    tick();
  endtask

  // SPI master: drops ready for 3 cycles per byte, CS low from first byte until 3 cycles after second.
  initial begin : spi_model
    cyc = 0; dv_cnt = 0; consec = 0; coincide = 0; cs_rise_cyc = 0; done_cyc = 0;
    sh = 0; nb = 0; prev_dv = 1'b0;
    for (int i = 0; i < NREQ; i++) ack_cnt[i] = 0;
    spi_tx_ready = 1'b1;
    spi_cs_n     = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (!i_Rst_L) begin
        sh = 0; nb = 0; prev_dv = 1'b0;
        spi_cs_n     = 1'b1;
        spi_tx_ready = !stall_ready;
      end else begin
        if (spi_tx_dv && prev_dv) consec++;
        prev_dv = spi_tx_dv;
        if ((req_ack & req_done) != '0) coincide++;
        for (int i = 0; i < NREQ; i++)
          if (req_ack[i]) begin
            ack_cnt[i]++;
            ack_order.push_back(i);
          end
        if (req_done != '0) done_cyc = cyc;
        if (spi_tx_dv) begin
          rx_q.push_back(spi_tx_byte);
          dv_cnt++;
          spi_cs_n = 1'b0;
          sh = 3;
          nb++;
        end else if (sh > 0) begin
          sh--;
          if (sh == 0 && nb == 2) begin
            spi_cs_n    = 1'b1;
            nb          = 0;
            cs_rise_cyc = cyc;
          end
        end
        spi_tx_ready = (sh == 0) && !stall_ready;
      end
    end
  end

  initial begin : sim_guard
    #200000;
    $display("FAIL sim_guard: got no finish expected finish before 200000");
    $fatal(1);
  end

  initial begin : stim
    int base, base2, n;
    req_valid = '0;
    req_frame = '0;
    repeat (3) @(negedge clk);
    #1 check_eq("reset_outs", outs(), 32'd0);
    @(negedge clk);
    i_Rst_L = 1'b1;
    tick();
    check_eq("post_reset_outs", outs(), 32'd0);

    // Single frame from requester 0
    req_frame[15:0] = POT_CMD_CFG;
    req_valid       = 3'b001;
    tick();
    check_eq("t1_ack", 32'(req_ack), 32'h1);
    check_eq("t1_busy_at_ack", 32'(busy), 32'd1);
    check_eq("t1_gid", 32'(grant_id), 32'd0);
    check_eq("t1_no_dv_at_ack", 32'(spi_tx_dv), 32'd0);
    tick();
    check_eq("t1_msb_dv", 32'(spi_tx_dv), 32'd1);
    check_eq("t1_msb_byte", 32'(spi_tx_byte), 32'h18);
    wait_done(0, 200);
    check_eq("t1_busy_at_done", 32'(busy), 32'd1);
    check_eq("t1_done_after_cs", 32'(done_cyc - cs_rise_cyc), 32'(GAP));
    tick();
    check_eq("t1_busy_after", 32'(busy), 32'd0);
    check_eq("t1_done_one_cycle", 32'(req_done), 32'd0);
    check_eq("t1_bytes", 32'(last_frame()), 32'h1802);
    check_eq("t1_ack_cnt", 32'(ack_cnt[0]), 32'd1);

    // Contention: 0 and 1 together after reset, then 0 and 2 with pointer at 1
    do_reset();
    base = ack_order.size();
    req_frame[15:0]  = POT_CMD_RESET;
    req_frame[31:16] = POT_CMD_CFG;
    req_valid        = 3'b011;
    wait_ack(0, 10);
    check_eq("t2_first_gid", 32'(grant_id), 32'd0);
    wait_done(0, 200);
    check_eq("t2_f0", 32'(last_frame()), 32'h1000);
    wait_ack(1, 20);
    check_eq("t2_second_gid", 32'(grant_id), 32'd1);
    wait_done(1, 200);
    check_eq("t2_f1", 32'(last_frame()), 32'h1802);
    check_eq("t2_order", 32'(ack_order[base] * 16 + ack_order[base+1]), 32'h01);
    base = ack_order.size();
    req_frame[47:32] = 16'hA55A;
    req_valid        = 3'b101;
    wait_ack(2, 20);
    check_eq("t2b_first_gid", 32'(grant_id), 32'd2);
    wait_done(2, 200);
    check_eq("t2b_f2", 32'(last_frame()), 32'hA55A);
    wait_done(0, 200);
    check_eq("t2b_f0", 32'(last_frame()), 32'h1000);
    check_eq("t2b_order", 32'(ack_order[base] * 16 + ack_order[base+1]), 32'h20);

    // Byte handshake with the LSB held off by a stalled master
    req_frame[31:16] = pot_wr_frame(10'h3FF);
    req_valid        = 3'b010;
    wait_ack(1, 20);
    tick();
    check_eq("t3_msb_dv", 32'(spi_tx_dv), 32'd1);
    check_eq("t3_msb_byte", 32'(spi_tx_byte), 32'h07);
    stall_ready = 1'b1;
    base = dv_cnt;
    repeat (20) tick();
    check_eq("t3_no_lsb_stalled", 32'(dv_cnt - base), 32'd0);
    stall_ready = 1'b0;
    wait_done(1, 200);
    check_eq("t3_bytes", 32'(last_frame()), 32'h07FF);

    // Watchdog abort with ready stuck low
    stall_ready = 1'b1;
    tick();
    tick();
    base = dv_cnt;
    req_frame[15:0] = POT_CMD_RESET;
    req_valid       = 3'b001;
    wait_ack(0, 20);
    n = 0;
    while (!timeout_err && n < 110) begin
      tick();
      n++;
    end
    check_eq("t4_terr", 32'(timeout_err), 32'd1);
    check_eq("t4_terr_within_101", 32'(n <= 101), 32'd1);
    wait_done(0, 50);
    check_eq("t4_no_dv", 32'(dv_cnt - base), 32'd0);
    stall_ready = 1'b0;
    req_frame[31:16] = POT_CMD_CFG;
    req_valid        = 3'b010;
    wait_done(1, 200);
    check_eq("t4_next_frame", 32'(last_frame()), 32'h1802);
    check_eq("t4_terr_sticky", 32'(timeout_err), 32'd1);

    // Reset during CSWAIT, then a fresh request from requester 1
    do_reset();
    check_eq("t5_terr_cleared", 32'(timeout_err), 32'd0);
    req_frame[47:32] = POT_CMD_CFG;
    base = dv_cnt;
    req_valid = 3'b100;
    n = 0;
    while (dv_cnt < base + 2 && n < 100) begin
      tick();
      n++;
    end
    check_eq("t5_two_bytes", 32'(dv_cnt - base), 32'd2);
    i_Rst_L = 1'b0;
    #1 check_eq("t5_async_reset_outs", outs(), 32'd0);
    tick();
    tick();
    i_Rst_L = 1'b1;
    req_frame[31:16] = pot_wr_frame(10'h155);
    req_valid        = 3'b010;
    tick();
    check_eq("t5_ack", 32'(req_ack), 32'h2);
    check_eq("t5_gid", 32'(grant_id), 32'd1);
    wait_done(1, 200);
    check_eq("t5_frame", 32'(last_frame()), 32'h0555);

    // Withdrawn request from 2 while 0 is in flight
    base  = ack_cnt[2];
    base2 = dv_cnt;
    req_frame[15:0] = POT_CMD_RESET;
    req_valid       = 3'b001;
    wait_ack(0, 20);
    req_valid[2] = 1'b1;
    tick();
    req_valid[2] = 1'b0;
    wait_done(0, 200);
    repeat (10) tick();
    check_eq("t6_no_ack2", 32'(ack_cnt[2] - base), 32'd0);
    check_eq("t6_only_two_bytes", 32'(dv_cnt - base2), 32'd2);
    check_eq("t6_idle", 32'(busy), 32'd0);

    check_eq("dv_never_back_to_back", 32'(consec), 32'd0);
    check_eq("ack_done_never_same", 32'(coincide), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
